pipe_run_ctrl: RTL and testbench

Execution controller for the 5-stage MIPS pipeline. Decides cycle by cycle whether the pipeline advances, using host commands (run, single-step, abort) and HALT detection in ID. After a HALT it stops fetch, drains the older instructions to WB, then freezes the pipeline. Its outputs gate every pipeline register, the PC and all architectural writes; it sits between the debug/host interface and the datapath.

---
 rtl/pipe_ctrl_pkg.sv | 22 ++
 rtl/pipe_run_ctrl_if.sv | 9 +
 rtl/pipe_run_ctrl_sat_counter.sv | 25 ++
 rtl/pipe_run_ctrl.sv | 103 ++++++++++
 tb/tb_pipe_run_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline run controller and the ID-stage HALT decoder.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_RUN   = 2'b01,
    CMD_STEP  = 2'b10,
    CMD_ABORT = 2'b11
  } cmd_e;

  // Primary opcode field value the ID decoder matches to raise halt_id.
  localparam logic [5:0] OP_HALT = 6'h3F;

endpackage

// File: rtl/pipe_run_ctrl_if.sv
// Host command channel: valid/ready handshake carrying a 2-bit command code.
interface pipe_run_ctrl_if;
  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/pipe_run_ctrl_sat_counter.sv
// Saturating up-counter, reusable for performance counters.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en && !(&count_q)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_run_ctrl.sv
// Run/step/halt controller gating every pipeline register, the PC and architectural writes.
module pipe_run_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NBITS        = 32,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  pipe_run_ctrl_if.slave    host,
  input  logic              halt_id,
  output logic              pipe_en,
  output logic              pc_en,
  output logic              if_bubble,
  output logic              step_done,
  output logic              halted,
  output logic [NBITS-1:0]  cycle_count
);

  state_e     state_q, state_d;
  logic [2:0] drain_q, drain_d;
  logic       pipe_en_q, pc_en_q, if_bubble_q, step_done_q, halted_q;
  logic       pipe_en_d, pc_en_d, if_bubble_d, step_done_d, halted_d;
  logic       cmd_acc;

  // A HALT in ID takes priority over any command, so the command is not consumed.
  assign host.cmd_ready = (state_q == ST_IDLE) || ((state_q == ST_RUN) && !halt_id);
  assign cmd_acc        = host.cmd_valid && host.cmd_ready;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_acc && (host.cmd == CMD_RUN))  state_d = ST_RUN;
        if (cmd_acc && (host.cmd == CMD_STEP)) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (halt_id) begin
          state_d = ST_DRAIN;
          drain_d = 3'(DRAIN_CYCLES);
        end else if (cmd_acc && (host.cmd == CMD_ABORT)) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (halt_id) begin
          state_d = ST_DRAIN;
          drain_d = 3'(DRAIN_CYCLES);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q - 3'd1;
        if (drain_q <= 3'd1) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state register.
    pipe_en_d   = (state_d == ST_RUN) || (state_d == ST_STEP) || (state_d == ST_DRAIN);
    pc_en_d     = (state_d == ST_RUN) || (state_d == ST_STEP);
    if_bubble_d = (state_d == ST_DRAIN);
    step_done_d = (state_d == ST_STEP);
    halted_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      drain_q     <= '0;
      pipe_en_q   <= 1'b0;
      pc_en_q     <= 1'b0;
      if_bubble_q <= 1'b0;
      step_done_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      pipe_en_q   <= pipe_en_d;
      pc_en_q     <= pc_en_d;
      if_bubble_q <= if_bubble_d;
      step_done_q <= step_done_d;
      halted_q    <= halted_d;
    end
  end

  assign pipe_en   = pipe_en_q;
  assign pc_en     = pc_en_q;
  assign if_bubble = if_bubble_q;
  assign step_done = step_done_q;
  assign halted    = halted_q;

  sat_counter #(.WIDTH(NBITS)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (pipe_en_q),
    .count (cycle_count)
  );

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Directed bench for pipe_run_ctrl: run/halt/drain, stepping, abort/resume, reset, saturation.
module tb_pipe_run_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic [5:0]  id_op;
  logic        halt_id;
  logic        pipe_en, pc_en, if_bubble, step_done, halted;
  logic [31:0] cycle_count;

  logic        halt_id2;
  logic        pipe_en2, pc_en2, if_bubble2, step_done2, halted2;
  logic [3:0]  cycle_count2;

  int unsigned n_chk;
  int unsigned n_bad;

  pipe_run_ctrl_if bif  ();
  pipe_run_ctrl_if bif2 ();

  assign halt_id = (id_op == OP_HALT);

  pipe_run_ctrl #(.NBITS(32), .DRAIN_CYCLES(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .host        (bif.slave),
    .halt_id     (halt_id),
    .pipe_en     (pipe_en),
    .pc_en       (pc_en),
    .if_bubble   (if_bubble),
    .step_done   (step_done),
    .halted      (halted),
    .cycle_count (cycle_count)
  );

  pipe_run_ctrl #(.NBITS(4), .DRAIN_CYCLES(3)) dut4 (
    .clk         (clk),
    .rst         (rst),
    .host        (bif2.slave),
    .halt_id     (halt_id2),
    .pipe_en     (pipe_en2),
    .pc_en       (pc_en2),
    .if_bubble   (if_bubble2),
    .step_done   (step_done2),
    .halted      (halted2),
    .cycle_count (cycle_count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic outs(input string tag, input logic pe, input logic pc,
                      input logic bub, input logic sd, input logic hl);
    chk({tag, ".pipe_en"},   32'(pipe_en),   32'(pe));
    chk({tag, ".pc_en"},     32'(pc_en),     32'(pc));
    chk({tag, ".if_bubble"}, 32'(if_bubble), 32'(bub));
    chk({tag, ".step_done"}, 32'(step_done), 32'(sd));
    chk({tag, ".halted"},    32'(halted),    32'(hl));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bif.cmd_valid  = 1'b0;
    bif.cmd        = CMD_NOP;
    bif2.cmd_valid = 1'b0;
    bif2.cmd       = CMD_NOP;
    id_op          = 6'h00;
    halt_id2       = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic send(input cmd_e c);
    bif.cmd_valid = 1'b1;
    bif.cmd       = c;
    tick();
    bif.cmd_valid = 1'b0;
    bif.cmd       = CMD_NOP;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk = 0;
    n_bad = 0;

    // Run, HALT after 10 active cycles, drain 3, done
    do_reset();
    outs("rst", 0, 0, 0, 0, 0);
    chk("rst.count", cycle_count, 0);
    chk("rst.ready", 32'(bif.cmd_ready), 1);
    send(CMD_RUN);
    outs("run", 1, 1, 0, 0, 0);
    chk("run.count0", cycle_count, 0);
    repeat (9) tick();
    chk("run.count9", cycle_count, 9);
    id_op = OP_HALT;
    #1;
    chk("halt.ready", 32'(bif.cmd_ready), 0);
    tick();
    id_op = 6'h00;
    for (int i = 0; i < 3; i++) begin
      outs($sformatf("drain%0d", i), 1, 0, 1, 0, 0);
      chk($sformatf("drain%0d.ready", i), 32'(bif.cmd_ready), 0);
      tick();
    end
    outs("done", 0, 0, 0, 0, 1);
    chk("done.count", cycle_count, 13);
    send(CMD_RUN);
    outs("done.hold", 0, 0, 0, 0, 1);
    chk("done.count_hold", cycle_count, 13);

    // Three single steps, two idle cycles apart
    do_reset();
    for (int k = 0; k < 3; k++) begin
      send(CMD_STEP);
      outs($sformatf("step%0d", k), 1, 1, 0, 1, 0);
      tick();
      outs($sformatf("step%0d.idle", k), 0, 0, 0, 0, 0);
      chk($sformatf("step%0d.ready", k), 32'(bif.cmd_ready), 1);
      tick();
    end
    chk("step.count", cycle_count, 3);

    // Abort after 5 active cycles, then resume
    do_reset();
    send(CMD_RUN);
    repeat (4) tick();
    chk("abort.ready", 32'(bif.cmd_ready), 1);
    send(CMD_ABORT);
    outs("abort", 0, 0, 0, 0, 0);
    chk("abort.count", cycle_count, 5);
    repeat (3) tick();
    chk("abort.gap_count", cycle_count, 5);
    send(CMD_RUN);
    outs("resume", 1, 1, 0, 0, 0);
    chk("resume.count0", cycle_count, 5);
    tick();
    chk("resume.count1", cycle_count, 6);
    chk("resume.halted", 32'(halted), 0);

    // ABORT coincident with HALT: HALT wins, ABORT never consumed
    do_reset();
    send(CMD_RUN);
    repeat (2) tick();
    bif.cmd_valid = 1'b1;
    bif.cmd       = CMD_ABORT;
    id_op         = OP_HALT;
    #1;
    chk("race.ready", 32'(bif.cmd_ready), 0);
    tick();
    id_op = 6'h00;
    outs("race.drain", 1, 0, 1, 0, 0);
    chk("race.drain_ready", 32'(bif.cmd_ready), 0);
    repeat (2) tick();
    chk("race.not_yet", 32'(halted), 0);
    tick();
    outs("race.done", 0, 0, 0, 0, 1);
    chk("race.count", cycle_count, 6);
    bif.cmd_valid = 1'b0;

    // Async reset during the second drain cycle
    do_reset();
    send(CMD_RUN);
    tick();
    id_op = OP_HALT;
    tick();
    id_op = 6'h00;
    tick();
    outs("mid.drain2", 1, 0, 1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    outs("mid.rst", 0, 0, 0, 0, 0);
    chk("mid.count", cycle_count, 0);
    tick();
    rst = 1'b0;
    tick();
    outs("mid.idle", 0, 0, 0, 0, 0);
    chk("mid.ready", 32'(bif.cmd_ready), 1);

    // 4-bit counter saturation
    do_reset();
    bif2.cmd_valid = 1'b1;
    bif2.cmd       = CMD_RUN;
    tick();
    bif2.cmd_valid = 1'b0;
    chk("sat.pipe_en", 32'(pipe_en2), 1);
    repeat (14) tick();
    chk("sat.count14", 32'(cycle_count2), 32'hE);
    tick();
    chk("sat.count15", 32'(cycle_count2), 32'hF);
    repeat (5) tick();
    chk("sat.hold", 32'(cycle_count2), 32'hF);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
